// File: rtl/pll_pkg.sv
// pll_pkg: shared definitions for clock-control blocks.
//   pll_state_e - sequencer state encoding (PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT)
//   pll_outs_t  - Moore output bundle decoded from a state
//   pll_decode  - state -> output decode
//   max3        - largest of three values, for sizing shared counters
package pll_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_state_e;

    typedef struct packed {
        logic pll_resetb;
        logic sys_reset;
        logic ready;
        logic fault;
    } pll_outs_t;

    function automatic pll_outs_t pll_decode(input pll_state_e s);
        pll_outs_t o;
        o.pll_resetb = 1'b0;
        o.sys_reset  = 1'b1;
        o.ready      = 1'b0;
        o.fault      = 1'b0;
        case (s)
            WAIT_LOCK, STABLE: o.pll_resetb = 1'b1;
            RUN: begin
                o.pll_resetb = 1'b1;
                o.sys_reset  = 1'b0;
                o.ready      = 1'b1;
            end
            FAULT:   o.fault = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level.
//   clk - destination clock
//   rst - asynchronous active-high reset, clears both flops to 0
//   d   - asynchronous input
//   q   - synchronized output, two clk cycles of latency
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: brings a PLL out of reset, waits for a stable lock, then
// releases the downstream reset. Retries a bounded number of times on lock
// timeout and parks in a terminal fault state when retries run out.
//   clk         - free-running reference clock (PLL input side)
//   reset       - asynchronous active-high reset
//   pll_locked  - raw PLL lock, asynchronous to clk
//   relock_req  - single-cycle request to re-sequence (honoured only in RUN)
//   pll_resetb  - active-low PLL reset
//   sys_reset   - active-high reset for PLL output-domain logic
//   ready       - PLL locked and stable, sys_reset released
//   fault       - retries exhausted, cleared only by reset
//   retry_count - retries used in the current acquisition, saturates at 3
module pll_lock_sequencer
    import pll_pkg::*;
#(
    parameter int unsigned PLL_RESET_CYCLES    = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_resetb,
    output logic       sys_reset,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retry_count
);

    localparam int unsigned CNT_MAX = max3(PLL_RESET_CYCLES, LOCK_STABLE_CYCLES,
                                           LOCK_TIMEOUT_CYCLES);
    localparam int unsigned CW = $clog2(CNT_MAX) + 1;
    localparam int unsigned RW = ($clog2(MAX_RETRIES + 1) > 2) ? $clog2(MAX_RETRIES + 1) : 2;

    localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RESET_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

    logic       lock_s;
    pll_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [1:0]    retry_cnt_d;
    pll_outs_t     outs_d;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (reset),
        .d   (pll_locked),
        .q   (lock_s)
    );

    // One counter serves every timed state; it is cleared on each state change
    // and never counts past the terminal value of the current state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        retry_d = retry_q;
        case (state_q)
            PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d = '0;
                    if (retry_q < RETRY_LIMIT) begin
                        retry_d = retry_q + RW'(1);
                        state_d = PLL_RST;
                    end else begin
                        state_d = FAULT;
                    end
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!lock_s || relock_req) state_d = PLL_RST;
            end
            FAULT: cnt_d = '0;
            default: begin
                state_d = PLL_RST;
                cnt_d   = '0;
            end
        endcase
        // Outputs are decoded from the next state so the registered outputs
        // always match the registered state.
        outs_d      = pll_decode(state_d);
        retry_cnt_d = (retry_d >= RW'(3)) ? 2'd3 : retry_d[1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_resetb  <= 1'b0;
            sys_reset   <= 1'b1;
            ready       <= 1'b0;
            fault       <= 1'b0;
            retry_count <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_resetb  <= outs_d.pll_resetb;
            sys_reset   <= outs_d.sys_reset;
            ready       <= outs_d.ready;
            fault       <= outs_d.fault;
            retry_count <= retry_cnt_d;
        end
    end

endmodule
